// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: priority layer composite over a background, frame-synced global fade, registered VGA pins.
module vga_layer_mixer #(
  parameter int          LAYERS      = 4,
  parameter logic [23:0] BG_COLR     = 24'h6BE9F2,
  parameter int          FADE_FRAMES = 2
) (
  input  logic                   i_clk_pix,
  input  logic                   i_rst_n,
  input  logic                   i_frame,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic                   i_de,
  input  logic [LAYERS-1:0]      i_layer_active,
  input  logic [LAYERS-1:0]      i_layer_drawing,
  input  logic [24*LAYERS-1:0]   i_layer_colr,
  input  logic                   i_fade_out,
  input  logic                   i_fade_in,
  output logic                   o_fade_busy,
  output logic                   o_fade_done,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b
);
  localparam int CW = $clog2(FADE_FRAMES + 1);
  typedef enum logic [1:0] {IDLE, FADE_OUT, BLACK, FADE_IN} state_t;
  state_t        state_q, state_d;
  logic [4:0]    level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [23:0]   colr_q, colr_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic          found;
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] l);
    logic [12:0] p;
    p = {5'd0, c} * {8'd0, l};
    return 8'(p >> 4);
  endfunction
  // The first active layer owns the pixel even where it is transparent.
  always_comb begin
    colr_d = BG_COLR;
    found = 1'b0;
    for (int k = 0; k < LAYERS; k++)
      if (!found && i_layer_active[k]) begin
        found = 1'b1;
        colr_d = i_layer_drawing[k] ? i_layer_colr[24*k +: 24] : BG_COLR;
      end
  end
  always_comb begin
    sync1_d = {i_hsync, i_vsync, i_de};
    sync2_d = sync1_q;
    rgb_d = sync1_q[0] ? {scale(colr_q[23:16], level_q), scale(colr_q[15:8], level_q),
                          scale(colr_q[7:0], level_q)} : 24'd0;
  end
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (i_fade_out && (state_q == IDLE || state_q == FADE_IN)) begin
      state_d = FADE_OUT;
      cnt_d = '0;
    end else if (i_fade_in && !i_fade_out && (state_q == BLACK || state_q == FADE_OUT)) begin
      state_d = FADE_IN;
      cnt_d = '0;
    end else if (o_fade_busy && i_frame) begin
      if (cnt_q == CW'(FADE_FRAMES - 1)) begin
        cnt_d = '0;
        level_d = state_q == FADE_OUT ? level_q - 5'd1 : level_q + 5'd1;
        if (level_d == 5'd0) begin
          state_d = BLACK;
          done_d = 1'b1;
        end else if (level_d == 5'd16) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      level_q <= 5'd16;
      cnt_q <= '0;
      done_q <= 1'b0;
      colr_q <= '0;
      rgb_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      colr_q <= colr_d;
      rgb_q <= rgb_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
  assign o_fade_busy = state_q == FADE_OUT || state_q == FADE_IN;
  assign o_fade_done = done_q;
  assign vga_hsync = sync2_q[2];
  assign vga_vsync = sync2_q[1];
  assign vga_blank_n = sync2_q[0];
  assign vga_sync_n = 1'b1;
  assign vga_r = rgb_q[23:16];
  assign vga_g = rgb_q[15:8];
  assign vga_b = rgb_q[7:0];
endmodule

// File: tb/tb_vga_layer_mixer.sv
// tb_vga_layer_mixer: vector table plus fade/reset sequences, scoreboarded against the 2-cycle pixel pipeline.
module tb_vga_layer_mixer;
  localparam logic [23:0] BG = 24'h6BE9F2;
  logic clk = 0, rst_n = 0, frame = 0, hs = 0, vs = 0, de = 0, fo = 0, fi = 0;
  logic [3:0] act = 0, drw = 0;
  logic [95:0] colr = {24'hA5C3E1, 24'h00FF00, 24'hFF0000, 24'h123456};
  logic busy, done, vhs, vvs, blank_n, sync_n;
  logic [7:0] r, g, b;
  logic [26:0] got;
  typedef struct {int due; logic [26:0] exp; string name;} sb_t;
  typedef struct {logic [3:0] a; logic [3:0] d; logic de; logic hs; logic vs; logic [26:0] exp; string name;} vec_t;
  sb_t q[$];
  vec_t vt[10];
  int cyc = 0, checks = 0, errors = 0, done_cnt = 0, d0 = 0;

  vga_layer_mixer dut (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .i_layer_active(act), .i_layer_drawing(drw), .i_layer_colr(colr),
    .i_fade_out(fo), .i_fade_in(fi), .o_fade_busy(busy), .o_fade_done(done),
    .vga_hsync(vhs), .vga_vsync(vvs), .vga_blank_n(blank_n), .vga_sync_n(sync_n),
    .vga_r(r), .vga_g(g), .vga_b(b)
  );

  always #5 clk = ~clk;
  assign got = {vhs, vvs, blank_n, r, g, b};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [23:0] sc(input logic [23:0] c, input int l);
    return {8'((c[23:16] * l) / 16), 8'((c[15:8] * l) / 16), 8'((c[7:0] * l) / 16)};
  endfunction

  task automatic chk(input string n, input logic [31:0] gv, input logic [31:0] ev);
    checks++;
    if (gv !== ev) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", n, gv, ev);
    end
  endtask

  task automatic push(input logic [26:0] e, input string n);
    sb_t s;
    s.due = cyc + 2;
    s.exp = e;
    s.name = n;
    q.push_back(s);
  endtask

  task automatic tick();
    sb_t s;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    done_cnt += int'(done);
    while (q.size() > 0 && q[0].due <= cyc) begin
      s = q.pop_front();
      checks++;
      if (s.due != cyc || got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h required %h (due %0d, cycle %0d)", s.name, got, s.exp, s.due, cyc);
      end
    end
  endtask

  task automatic pixl(input logic [23:0] e, input string n);
    act = 0; drw = 0; de = 1; hs = 0; vs = 0;
    push({3'b001, e}, n);
    repeat (3) tick();
  endtask

  task automatic pix(input int l, input string n);
    pixl(sc(BG, l), n);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame = 1; tick(); frame = 0; tick();
    end
  endtask

  task automatic pulse(input logic o, input logic i);
    fo = o; fi = i; tick(); fo = 0; fi = 0;
  endtask

  initial begin
    vt[0] = '{4'b0000, 4'b0000, 1, 1, 0, {3'b101, BG}, "none_de1"};
    vt[1] = '{4'b0000, 4'b0000, 0, 0, 1, {3'b010, 24'h0}, "none_de0"};
    vt[2] = '{4'b0110, 4'b0100, 1, 0, 0, {3'b001, BG}, "win1_nodraw"};
    vt[3] = '{4'b0110, 4'b0010, 1, 0, 0, {3'b001, 24'hFF0000}, "win1_draw"};
    vt[4] = '{4'b1111, 4'b1111, 1, 1, 1, {3'b111, 24'h123456}, "all_layer0"};
    vt[5] = '{4'b1000, 4'b1000, 1, 0, 0, {3'b001, 24'hA5C3E1}, "only_layer3"};
    vt[6] = '{4'b1000, 4'b0111, 1, 0, 0, {3'b001, BG}, "layer3_nodraw"};
    vt[7] = '{4'b0100, 4'b0110, 1, 0, 0, {3'b001, 24'h00FF00}, "layer2_draw"};
    vt[8] = '{4'b1111, 4'b1111, 0, 1, 0, {3'b100, 24'h0}, "blank_active"};
    vt[9] = '{4'b0001, 4'b0000, 1, 0, 1, {3'b011, BG}, "layer0_nodraw"};

    rst_n = 0; de = 1; hs = 1; vs = 1; act = 4'b0001; drw = 4'b0001;
    repeat (3) tick();
    chk("reset_pins", got, 27'h0);
    chk("reset_sync_n", sync_n, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1;

    for (int i = 0; i < 10; i++) begin
      act = vt[i].a; drw = vt[i].d; de = vt[i].de; hs = vt[i].hs; vs = vt[i].vs;
      push(vt[i].exp, vt[i].name);
      tick();
    end
    repeat (3) tick();

    pulse(0, 1);
    chk("fade_in_idle_busy", busy, 0);
    frames(2);
    pix(16, "fade_in_idle_level");

    d0 = done_cnt;
    pulse(1, 1);
    chk("both_busy", busy, 1);
    frames(1);
    pix(16, "fo_frame1");
    frames(1);
    pix(15, "fo_frame2");
    frames(14);
    pixl(24'h357479, "fo_level8");

    pulse(0, 1);
    chk("rev_busy", busy, 1);
    frames(2);
    pix(9, "rev_level9");
    frames(12);
    pix(15, "rev_level15");
    chk("rev_no_early_done", done_cnt - d0, 0);
    frames(2);
    chk("rev_done_once", done_cnt - d0, 1);
    chk("rev_idle_busy", busy, 0);
    pix(16, "rev_level16");

    d0 = done_cnt;
    pulse(1, 0);
    frames(31);
    chk("fo_no_early_done", done_cnt - d0, 0);
    frames(1);
    chk("fo_done_once", done_cnt - d0, 1);
    chk("black_busy", busy, 0);
    pixl(24'h0, "black_level0");
    pulse(1, 0);
    frames(2);
    chk("black_fo_ignored", busy, 0);

    pulse(0, 1);
    frames(10);
    pixl(24'h21484B, "fi_level5");
    pulse(1, 0);
    chk("rev_out_busy", busy, 1);
    frames(1);
    pixl(24'h21484B, "fo_level5");

    rst_n = 0; hs = 1; vs = 1; de = 1;
    tick();
    chk("midfade_reset_pins", got, 27'h0);
    chk("midfade_reset_sync_n", sync_n, 1);
    chk("midfade_reset_busy", busy, 0);
    rst_n = 1;
    pix(16, "post_reset_full");
    chk("post_reset_busy", busy, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_layer_mixer.md
# vga_layer_mixer

Parametrised successor to the fixed two-layer colour select in the top level: composites up to LAYERS sprite/scene layers over a constant background, applies a frame-synchronous global fade (out to black / in from black), and drives the registered VGA pins. Sits between the per-scene renderers (menu, main game, future overlays) and the board VGA DAC. Sync signals are delayed to match the colour pipeline, so the top level only wires through.

## Interface
Parameters:
- LAYERS, 4, number of layer inputs; index 0 has highest priority
- BG_COLR, 24'h6BE9F2, background RGB {R,G,B}
- FADE_FRAMES, 2, frames per fade step (≥1)

Ports:
- i_clk_pix  in  1  pixel clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_frame  in  1  one-cycle pulse at frame start from display_signal
- i_hsync, i_vsync, i_de  in  1 each  raw sync/data-enable from display_signal
- i_layer_active  in  LAYERS  layer owns the screen this frame (processing)
- i_layer_drawing  in  LAYERS  layer has an opaque pixel at current sx/sy
- i_layer_colr  in  24*LAYERS  layer k colour at bits [24k+23:24k], {R,G,B}
- i_fade_out  in  1  pulse: start fade to black
- i_fade_in  in  1  pulse: start fade from black
- o_fade_busy  out  1  high in FADE_OUT or FADE_IN
- o_fade_done  out  1  one-cycle pulse when a fade completes
- vga_hsync, vga_vsync, vga_blank_n, vga_sync_n  out  1 each
- vga_r, vga_g, vga_b  out  8 each

## Operation
- Stage 1 (select, registered): winner = lowest index k with i_layer_active[k]=1. If a winner exists and i_layer_drawing[winner]=1, colour = its i_layer_colr; otherwise BG_COLR. Lower-priority layers never show through, even where the winner is not drawing (matches current menu-over-game behaviour). No active layer → BG_COLR.
- Stage 2 (scale, registered): each channel out = (c * level) >> 4; c 8 bits, level 5 bits (0..16), product 13 bits. level 16 → exact c; level 0 → 0. Output forced to 0 when delayed de = 0.
- vga_blank_n = de delayed; vga_sync_n constant 1 out of reset.
- Fade FSM states: IDLE (level 16), FADE_OUT, BLACK (level 0), FADE_IN.
  - IDLE or FADE_IN + i_fade_out → FADE_OUT; frame counter cleared.
  - BLACK or FADE_OUT + i_fade_in → FADE_IN; frame counter cleared.
  - i_fade_out and i_fade_in same cycle: i_fade_out wins.
  - i_fade_out in FADE_OUT/BLACK, i_fade_in in FADE_IN/IDLE: ignored.
  - In FADE_OUT/FADE_IN: frame counter increments on each i_frame; when it reaches FADE_FRAMES it clears and level steps −1/+1 in the same cycle.
  - Step taking level to 0 → BLACK; to 16 → IDLE; o_fade_done pulses for that one cycle.
  - Reversal mid-fade continues from current level (no jump).
- Level changes only on i_frame cycles, so a frame never shows two levels except the frame-start pixel pipeline (acceptable: i_frame fires in blanking).

## Timing
- Latency: inputs (sync, layer bits, colours) to VGA pins = 2 cycles; sync/de delayed by the same 2 registers, so alignment is preserved.
- Level sampled in stage 2 at the same cycle the colour is scaled.
- Reset (i_rst_n low at a clock edge): all pipeline regs 0, vga_r/g/b 0, vga_hsync/vsync 0, vga_blank_n 0, vga_sync_n 1, state IDLE, level 16, frame counter 0, o_fade_busy 0, o_fade_done 0. Reset mid-fade aborts immediately to IDLE at full brightness.
- Full fade duration = 16*FADE_FRAMES frames (32 at default), measured from first i_frame after the request.

## Test plan
- No layer active, de=1 → after 2 cycles vga_r/g/b = 6B/E9/F2, blank_n=1; de=0 → 00/00/00, blank_n=0.
- active=4'b0110, drawing=4'b0100, colr1=FF0000, colr2=00FF00 → output = BG (layer 1 wins, not drawing); drawing=4'b0010 → FF0000.
- i_fade_out in IDLE, FADE_FRAMES=2: level 15 after 2nd i_frame, 8 after 16th (BG → 35/74/79), 0 after 32nd with o_fade_done pulse, state BLACK, o_fade_busy low.
- From level 8 in FADE_OUT, assert i_fade_in → level rises 9..16 over 16 frames, o_fade_done pulses once on reaching IDLE.
- i_fade_out and i_fade_in same cycle in IDLE → FADE_OUT entered; i_fade_in alone in IDLE → no change.
- Assert i_rst_n=0 for one cycle mid FADE_OUT at level 5 → next cycle level 16, IDLE, all VGA outputs at reset values, sync_n=1.
